// File: rtl/int_exec_unit.sv
// Integer execution unit: single-cycle ADD/SUB/ADDI/address/branch/JAL
// results plus a multi-cycle shift-add multiplier, with a one-entry
// valid/ready output register.
module int_exec_unit #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rsn_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] data_a_i,
    input  logic [XLEN-1:0] data_b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] data_out_o,
    output logic            branch_taken_o,
    output logic            illegal_o
);

    localparam int unsigned STEPS = XLEN / MUL_STEP;
    localparam int unsigned CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] STEP_DONE = CNT_W'(STEPS);

    typedef enum logic {
        IDLE,
        MUL
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  step_q;
    logic [CNT_W-1:0]  step_d;
    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   acc_d;
    logic              valid_q;
    logic [XLEN-1:0]   data_q;
    logic              taken_q;
    logic              illegal_q;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   imm_b;
    logic [XLEN-1:0]   imm_j;
    logic [XLEN-1:0]   res_d;
    logic              taken_d;
    logic              illegal_d;
    logic              is_mul_d;
    logic              accept;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

    // Output slot is free or draining this edge; nothing accepted while multiplying.
    assign ready_o = (state_q == IDLE) && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;

    assign valid_o        = valid_q;
    assign data_out_o     = data_q;
    assign branch_taken_o = taken_q;
    assign illegal_o      = illegal_q;

    assign step_d = step_q + 1'b1;

    // Decode the request and compute the single-cycle result.
    always_comb begin
        res_d     = '0;
        taken_d   = 1'b0;
        illegal_d = 1'b1;
        is_mul_d  = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (funct3 == 3'b000) begin
                    case (funct7)
                        7'b0000000: begin
                            res_d     = data_a_i + data_b_i;
                            illegal_d = 1'b0;
                        end
                        7'b0100000: begin
                            res_d     = data_a_i - data_b_i;
                            illegal_d = 1'b0;
                        end
                        7'b0000001: begin
                            is_mul_d  = 1'b1;
                            illegal_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            7'b0010011: begin
                if (funct3 == 3'b000) begin
                    res_d     = data_a_i + imm_i;
                    illegal_d = 1'b0;
                end
            end
            7'b0000011: begin
                res_d     = data_a_i + imm_i;
                illegal_d = 1'b0;
            end
            7'b0100011: begin
                res_d     = data_a_i + imm_s;
                illegal_d = 1'b0;
            end
            7'b1100011: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    taken_d   = funct3[0] ? (data_a_i != data_b_i) : (data_a_i == data_b_i);
                    res_d     = taken_d ? (pc_i + imm_b) : (pc_i + XLEN'(4));
                    illegal_d = 1'b0;
                end
            end
            7'b1101111: begin
                res_d     = pc_i + imm_j;
                taken_d   = 1'b1;
                illegal_d = 1'b0;
            end
            default: ;
        endcase
    end

    // One multiplier step: add the shifted multiplicand for each of the next MUL_STEP bits.
    always_comb begin
        acc_d = acc_q;
        for (int unsigned j = 0; j < MUL_STEP; j++) begin
            if (mplier_q[j]) begin
                acc_d = acc_d + (mcand_q << j);
            end
        end
    end

    // Control FSM, multiplier datapath and registered result slot.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q   <= IDLE;
            step_q    <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_mul_d) begin
                            state_q  <= MUL;
                            step_q   <= '0;
                            acc_q    <= '0;
                            mcand_q  <= data_a_i;
                            mplier_q <= data_b_i;
                            valid_q  <= 1'b0;
                        end else begin
                            valid_q   <= 1'b1;
                            data_q    <= res_d;
                            taken_q   <= taken_d;
                            illegal_q <= illegal_d;
                        end
                    end else if (valid_q && ready_i) begin
                        valid_q <= 1'b0;
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << MUL_STEP;
                    mplier_q <= mplier_q >> MUL_STEP;
                    if (step_d == STEP_DONE) begin
                        state_q   <= IDLE;
                        step_q    <= '0;
                        valid_q   <= 1'b1;
                        data_q    <= acc_d;
                        taken_q   <= 1'b0;
                        illegal_q <= 1'b0;
                    end else begin
                        step_q <= step_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_exec_unit.sv
// Bench for int_exec_unit: two instances (MUL_STEP 1 and 4) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_int_exec_unit;

    typedef struct packed {
        logic        is_mul;
        logic        taken;
        logic        ill;
        logic [63:0] data;
    } res_t;

    logic        clk = 1'b0;
    logic        rsn;
    logic        v0, v1, r0, r1;
    logic [63:0] pc, a, b;
    logic [31:0] instr;
    logic        ro0, ro1, vo0, vo1, bt0, bt1, il0, il1;
    logic [63:0] d0, d1;
    int          vectors = 0;
    int          miscompares = 0;

    int_exec_unit #(.XLEN(64), .MUL_STEP(1)) u_dut_s1 (
        .clk_i(clk), .rsn_i(rsn), .valid_i(v0), .ready_o(ro0), .pc_i(pc),
        .instr_i(instr), .data_a_i(a), .data_b_i(b), .valid_o(vo0),
        .ready_i(r0), .data_out_o(d0), .branch_taken_o(bt0), .illegal_o(il0)
    );

    int_exec_unit #(.XLEN(64), .MUL_STEP(4)) u_dut_s4 (
        .clk_i(clk), .rsn_i(rsn), .valid_i(v1), .ready_o(ro1), .pc_i(pc),
        .instr_i(instr), .data_a_i(a), .data_b_i(b), .valid_o(vo1),
        .ready_i(r1), .data_out_o(d1), .branch_taken_o(bt1), .illegal_o(il1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    function automatic logic o_ready(input int k);  return (k == 0) ? ro0 : ro1; endfunction
    function automatic logic o_valid(input int k);  return (k == 0) ? vo0 : vo1; endfunction
    function automatic logic o_taken(input int k);  return (k == 0) ? bt0 : bt1; endfunction
    function automatic logic o_ill(input int k);    return (k == 0) ? il0 : il1; endfunction
    function automatic logic [63:0] o_data(input int k); return (k == 0) ? d0 : d1; endfunction
    function automatic logic i_valid(input int k);  return (k == 0) ? v0 : v1; endfunction
    function automatic logic i_ready(input int k);  return (k == 0) ? r0 : r1; endfunction
    function automatic int steps(input int k);      return (k == 0) ? 64 : 16; endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Architectural meaning of one instruction, from RISC-V field rules.
    function automatic res_t golden(input logic [63:0] p, input logic [31:0] ins,
                                    input logic [63:0] x, input logic [63:0] y);
        res_t r;
        logic signed [31:0] t;
        logic signed [63:0] imm_i, imm_s, imm_b, imm_j;
        t = $signed(ins) >>> 20;                                                      imm_i = t;
        t = $signed({ins[31:25], ins[11:7], 20'b0}) >>> 20;                          imm_s = t;
        t = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0}) >>> 19;   imm_b = t;
        t = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0}) >>> 11; imm_j = t;
        r = '0;
        r.ill = 1'b1;
        case (ins[6:0])
            7'h33: if (ins[14:12] == 3'd0) begin
                if (ins[31:25] == 7'h00)      begin r.ill = 1'b0; r.data = x + y; end
                else if (ins[31:25] == 7'h20) begin r.ill = 1'b0; r.data = x - y; end
                else if (ins[31:25] == 7'h01) begin r.ill = 1'b0; r.is_mul = 1'b1; r.data = x * y; end
            end
            7'h13: if (ins[14:12] == 3'd0) begin r.ill = 1'b0; r.data = x + imm_i; end
            7'h03: begin r.ill = 1'b0; r.data = x + imm_i; end
            7'h23: begin r.ill = 1'b0; r.data = x + imm_s; end
            7'h63: if (ins[14:13] == 2'b00) begin
                r.ill   = 1'b0;
                r.taken = ins[12] ? (x != y) : (x == y);
                r.data  = r.taken ? p + imm_b : p + 64'd4;
            end
            7'h6F: begin r.ill = 1'b0; r.taken = 1'b1; r.data = p + imm_j; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [6:0] op);
        return {imm, 5'd1, 3'b000, 5'd3, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm);
        return {imm[11:5], 5'd2, 5'd1, 3'b011, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    // Model: per-instance result slot plus a countdown for an in-flight multiply.
    res_t        gold;
    int          m_busy  [2];
    logic        m_valid [2];
    logic        m_taken [2];
    logic        m_ill   [2];
    logic [63:0] m_data  [2];
    logic [63:0] m_prod  [2];

    always_comb gold = golden(pc, instr, a, b);

    always @(posedge clk or negedge rsn) begin
        for (int k = 0; k < 2; k++) begin
            if (!rsn) begin
                m_busy[k]  <= 0;
                m_valid[k] <= 1'b0;
                m_taken[k] <= 1'b0;
                m_ill[k]   <= 1'b0;
                m_data[k]  <= '0;
                m_prod[k]  <= '0;
            end else if (m_busy[k] != 0) begin
                m_busy[k] <= m_busy[k] - 1;
                if (m_busy[k] == 1) begin
                    m_valid[k] <= 1'b1;
                    m_data[k]  <= m_prod[k];
                    m_taken[k] <= 1'b0;
                    m_ill[k]   <= 1'b0;
                end
            end else if (i_valid(k) && (!m_valid[k] || i_ready(k))) begin
                if (gold.is_mul) begin
                    m_busy[k]  <= steps(k);
                    m_prod[k]  <= gold.data;
                    m_valid[k] <= 1'b0;
                end else begin
                    m_valid[k] <= 1'b1;
                    m_data[k]  <= gold.data;
                    m_taken[k] <= gold.taken;
                    m_ill[k]   <= gold.ill;
                end
            end else if (m_valid[k] && i_ready(k)) begin
                m_valid[k] <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rsn === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_ready[%0d]", k), o_ready(k),
                    (m_busy[k] == 0) && (!m_valid[k] || i_ready(k)));
                chk($sformatf("model_valid[%0d]", k), o_valid(k), m_valid[k]);
                if (m_valid[k]) begin
                    chk($sformatf("model_data[%0d]", k),  o_data(k),  m_data[k]);
                    chk($sformatf("model_taken[%0d]", k), o_taken(k), m_taken[k]);
                    chk($sformatf("model_ill[%0d]", k),   o_ill(k),   m_ill[k]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic [63:0] p, input logic [31:0] ins,
                         input logic [63:0] x, input logic [63:0] y);
        pc = p; instr = ins; a = x; b = y;
        if (k == 0) v0 = 1'b1; else v1 = 1'b1;
        #1;
        chk("issue_ready", o_ready(k), 1'b1);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic mul_run(input int k, input logic [63:0] x, input logic [63:0] y,
                           input int lat, input logic [63:0] exp, input string tag);
        int cyc;
        int busy_rdy;
        cyc = 0;
        busy_rdy = 0;
        issue(k, 64'h0, enc_r(7'h01, 3'b000), x, y);
        while (!o_valid(k) && cyc < 300) begin
            if (o_ready(k)) busy_rdy++;
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_busy_ready"}, busy_rdy, 0);
        chk({tag, "_data"}, o_data(k), exp);
        chk({tag, "_ill"}, o_ill(k), 1'b0);
        tick();
    endtask

    initial begin
        int stale;
        rsn = 1'b0; v0 = 1'b0; v1 = 1'b0; r0 = 1'b1; r1 = 1'b1;
        pc = '0; instr = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", o_valid(k), 1'b0);
            chk("rst_data",  o_data(k),  64'h0);
            chk("rst_taken", o_taken(k), 1'b0);
            chk("rst_ill",   o_ill(k),   1'b0);
        end
        rsn = 1'b1;
        #1;
        chk("rel_ready0", ro0, 1'b1);
        chk("rel_ready1", ro1, 1'b1);
        tick();

        issue(0, 64'h0, enc_r(7'h00, 3'b000), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add_valid", vo0, 1'b1);
        chk("add_data", d0, 64'h0);
        chk("add_ill", il0, 1'b0);
        tick();
        chk("add_drained", vo0, 1'b0);

        issue(0, 64'h0, enc_r(7'h20, 3'b000), 64'd5, 64'd7);
        chk("sub_data", d0, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(0, 64'h1000, enc_b(13'h1FF8, 3'b001), 64'd1, 64'd2);
        chk("bne_t_data", d0, 64'hFF8);
        chk("bne_t_taken", bt0, 1'b1);
        issue(0, 64'h1000, enc_b(13'h1FF8, 3'b001), 64'd2, 64'd2);
        chk("bne_n_data", d0, 64'h1004);
        chk("bne_n_taken", bt0, 1'b0);
        issue(0, 64'h2000, enc_b(13'd16, 3'b000), 64'd9, 64'd9);
        chk("beq_data", d0, 64'h2010);
        chk("beq_taken", bt0, 1'b1);
        issue(0, 64'h3000, enc_j(21'h1FFFFC), 64'd0, 64'd0);
        chk("jal_data", d0, 64'h2FFC);
        chk("jal_taken", bt0, 1'b1);
        issue(0, 64'h0, enc_i(12'hFFF, 7'b0000011), 64'h100, 64'd0);
        chk("load_data", d0, 64'hFF);
        issue(0, 64'h0, enc_s(12'h7F0), 64'h10, 64'd0);
        chk("store_data", d0, 64'h800);
        issue(0, 64'h0, enc_s(12'h800), 64'h1000, 64'd0);
        issue(0, 64'h0, enc_i(12'h005, 7'b0010011), 64'd10, 64'd0);
        chk("addi_data", d0, 64'd15);
        issue(0, 64'h0, 32'h0000_007F, 64'd5, 64'd6);
        chk("ill_valid", vo0, 1'b1);
        chk("ill_flag", il0, 1'b1);
        chk("ill_data", d0, 64'h0);
        chk("ill_taken", bt0, 1'b0);
        issue(0, 64'h0, enc_b(13'd8, 3'b100), 64'd1, 64'd2);
        chk("blt_ill", il0, 1'b1);
        issue(0, 64'h0, enc_r(7'h02, 3'b000), 64'd1, 64'd2);
        issue(0, 64'h0, enc_r(7'h00, 3'b001), 64'd1, 64'd2);
        issue(0, 64'h0, enc_i(12'h001, 7'b0010011) | 32'h0000_1000, 64'd1, 64'd0);
        tick();

        r0 = 1'b0;
        issue(0, 64'h0, enc_i(12'hFFF, 7'b0010011), 64'd100, 64'd0);
        chk("bp_first", d0, 64'd99);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", vo0, 1'b1);
            chk("bp_data", d0, 64'd99);
            chk("bp_ready", ro0, 1'b0);
        end
        r0 = 1'b1;
        issue(0, 64'h0, enc_r(7'h00, 3'b000), 64'd7, 64'd8);
        chk("b2b_valid", vo0, 1'b1);
        chk("b2b_data", d0, 64'd15);
        tick();

        mul_run(0, 64'd3, 64'd5, 64, 64'd15, "mul_s1");
        mul_run(1, 64'd3, 64'd5, 16, 64'd15, "mul_s4");
        mul_run(0, 64'hDEAD_BEEF_1234_5678, 64'h0FED_CBA9_8765_4321, 64,
                64'hDEAD_BEEF_1234_5678 * 64'h0FED_CBA9_8765_4321, "mul_big_s1");
        mul_run(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16, 64'd1, "mul_ones_s4");
        issue(1, 64'h0, enc_r(7'h00, 3'b000), 64'd2, 64'd3);
        mul_run(1, 64'h8000_0000_0000_0001, 64'd6, 16, 64'd6, "mul_drain_s4");

        issue(0, 64'h0, enc_r(7'h01, 3'b000), 64'd3, 64'd5);
        repeat (10) tick();
        rsn = 1'b0;
        #1;
        chk("mulrst_valid", vo0, 1'b0);
        chk("mulrst_data", d0, 64'h0);
        @(posedge clk);
        #1;
        rsn = 1'b1;
        #1;
        chk("mulrst_ready", ro0, 1'b1);
        stale = 0;
        repeat (80) begin
            tick();
            if (vo0) stale++;
        end
        chk("mulrst_stale", stale, 0);

        issue(0, 64'h0, enc_r(7'h00, 3'b000), 64'd1, 64'd1);
        chk("post_rst_add", d0, 64'd2);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/int_exec_unit.md
INT_EXEC_UNIT -- requirements
Module: int_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter MUL_STEP, default 1, multiplier bits retired per cycle; legal values 1, 2, 4, 8.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rsn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i  input  1  request valid.
REQ-006 SHALL have port ready_o  output  1  unit can accept a request.
REQ-007 SHALL have port pc_i  input  XLEN  instruction PC.
REQ-008 SHALL have port instr_i  input  32  RV instruction word.
REQ-009 SHALL have ports data_a_i and data_b_i  input  XLEN  operands rs1 and rs2.
REQ-010 SHALL have port valid_o  output  1  result valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts result.
REQ-012 SHALL have port data_out_o  output  XLEN  result.
REQ-013 SHALL have port branch_taken_o  output  1  branch or jump redirects PC; qualified by valid_o.
REQ-014 SHALL have port illegal_o  output  1  unsupported encoding; qualified by valid_o.

Function
REQ-015 SHALL accept a request on a rising edge where valid_i and ready_o are both 1; ready_o = (state==IDLE) and (valid_o==0 or ready_i==1).
REQ-016 SHALL implement FSM states IDLE, MUL: IDLE->MUL on accepting MUL; MUL->IDLE when the step counter reaches XLEN/MUL_STEP; all other accepts stay in IDLE.
REQ-017 SHALL register non-MUL results on the accept edge; valid_o is 1 in the following cycle (latency 1).
REQ-018 SHALL, for MUL, assert valid_o exactly XLEN/MUL_STEP cycles after the accept edge; ready_o is 0 throughout MUL.
REQ-019 SHALL decode opcode 0110011/funct3 000: funct7 0000000 ADD a+b; 0100000 SUB a-b; 0000001 MUL, low XLEN bits of a*b, unsigned shift-add, MUL_STEP bits per cycle.
REQ-020 SHALL decode opcode 0010011/funct3 000 ADDI: a + sext(instr[31:20]).
REQ-021 SHALL decode opcode 0000011 load address: a + sext(instr[31:20]).
REQ-022 SHALL decode opcode 0100011 store address: a + sext({instr[31:25],instr[11:7]}).
REQ-023 SHALL decode opcode 1100011: funct3 000 BEQ taken if a==b; 001 BNE taken if a!=b; result pc+Bimm if taken, else pc+4; branch_taken_o = taken.
REQ-024 SHALL decode opcode 1101111 JAL: result pc+Jimm; branch_taken_o = 1.
REQ-025 SHALL sign-extend every immediate from its top bit (instr[31]) to XLEN; B and J immediates have bit 0 = 0.
REQ-026 SHALL wrap all arithmetic modulo 2^XLEN with no overflow flag.
REQ-027 SHALL, for any other encoding, produce data_out_o=0, illegal_o=1, branch_taken_o=0, latency 1.
REQ-028 SHALL hold data_out_o, branch_taken_o, illegal_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-029 SHALL clear valid_o on an edge where valid_o=1 and ready_i=1, unless a new result is loaded on that edge, which sets valid_o=1 back-to-back.
REQ-030 SHALL, on MUL completion with a pending unaccepted result, never occur, because MUL entry requires the output slot to be free or draining.
REQ-031 SHALL ignore valid_i while ready_o=0; operands are captured only on accept.

Reset
REQ-032 SHALL, on rsn_i=0, asynchronously force state=IDLE, step counter=0, valid_o=0, data_out_o=0, branch_taken_o=0, illegal_o=0.
REQ-033 SHALL abort any in-flight MUL on reset, with no result emitted afterwards.
REQ-034 SHALL drive ready_o=1 in the first cycle after rsn_i deasserts.

Verification
REQ-035 SHALL verify ADD: a=0xFFFF_FFFF_FFFF_FFFF, b=1, ready_i=1 -> next cycle valid_o=1, data_out_o=0.
REQ-036 SHALL verify MUL with XLEN=64, MUL_STEP=1: a=3, b=5 -> ready_o=0 for 64 cycles, valid_o at cycle 64, data_out_o=15; repeat with MUL_STEP=4 -> valid_o at cycle 16.
REQ-037 SHALL verify BNE: pc=0x1000, a=1, b=2, Bimm=-8 -> data_out_o=0xFF8, branch_taken_o=1; with a=b -> data_out_o=0x1004, branch_taken_o=0.
REQ-038 SHALL verify backpressure: ADDI result with ready_i=0 for 5 cycles -> outputs constant, ready_o=0; ready_i=1 with a new valid_i -> back-to-back valid_o.
REQ-039 SHALL verify reset at cycle 10 of a MUL -> valid_o=0 immediately, ready_o=1 after release, and no stale result appears.
REQ-040 SHALL verify an illegal opcode 0x7F -> illegal_o=1, data_out_o=0, latency 1.
